// File: rtl/operand_loader_int32_if.sv
// Operand stream (serial in) and triple stream (parallel out) between a source,
// the operand loader and the combinational add/sub stage.
interface operand_loader_int32_if #(
  parameter int unsigned WIDTH = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] C;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, A, B, C
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, A, B, C
  );
endinterface

// File: rtl/operand_loader_int32.sv
// Serial-to-parallel operand loader: collects A, B, C words from one stream and
// presents each complete triple to the add/sub stage with a valid/ready handshake.
module operand_loader_int32 #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  operand_loader_int32_if.slave bus,
  output logic [CNT_WIDTH-1:0] triple_count
);

  typedef enum logic [1:0] {S_A, S_B, S_C, S_OUT} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     a_q, a_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic [WIDTH-1:0]     c_q, c_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  logic in_ready_s;
  logic out_valid_s;
  logic in_fire;
  logic out_fire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_A;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_fire  = bus.in_valid & in_ready_s;
  assign out_fire = out_valid_s & bus.out_ready;

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    c_d     = c_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = S_A;
      a_d     = '0;
      b_d     = '0;
      c_d     = '0;
    end else begin
      if (out_fire) cnt_d = cnt_q + CNT_WIDTH'(1);
      case (state_q)
        S_A: if (in_fire) begin
          a_d     = bus.in_data;
          state_d = S_B;
        end
        S_B: if (in_fire) begin
          b_d     = bus.in_data;
          state_d = S_C;
        end
        S_C: if (in_fire) begin
          c_d     = bus.in_data;
          state_d = S_OUT;
        end
        S_OUT: if (out_fire) begin
          // Accepting the next A while the triple leaves keeps a 3-cycle cadence.
          if (in_fire) begin
            a_d     = bus.in_data;
            state_d = S_B;
          end else begin
            state_d = S_A;
          end
        end
        default: state_d = S_A;
      endcase
    end
  end

  always_comb begin
    out_valid_s = (state_q == S_OUT);
    in_ready_s  = (state_q == S_OUT) ? bus.out_ready : 1'b1;
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_s;
  assign bus.A         = a_q;
  assign bus.B         = b_q;
  assign bus.C         = c_q;
  assign triple_count  = cnt_q;

endmodule

// File: tb/tb_operand_loader_int32.sv
// Scoreboard bench for operand_loader_int32: expected triples are queued as they
// are driven and checked (with Y = A + B - C) when the loader hands them off.
module tb_operand_loader_int32;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic [15:0] triple_count;
  logic [3:0]  cnt4;

  int n_cmp = 0;
  int n_err = 0;
  int unsigned stalls = 0;
  int unsigned cyc = 0;

  logic [95:0]  sb[$];
  int unsigned  out_cycles[$];

  operand_loader_int32_if #(.WIDTH(32)) bus ();
  operand_loader_int32_if #(.WIDTH(32)) bus4 ();

  operand_loader_int32 #(.WIDTH(32), .CNT_WIDTH(16)) u_dut (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus), .triple_count(triple_count)
  );

  operand_loader_int32 #(.WIDTH(32), .CNT_WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .flush(1'b0), .bus(bus4), .triple_count(cnt4)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: pops the scoreboard on each real output transfer.
  always @(negedge clk) begin
    logic [95:0] exp_t;
    logic [31:0] exp_y;
    logic [31:0] obs_y;
    if (!rst && !flush && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (sb.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_output: got A=%h B=%h C=%h, required no transfer", bus.A, bus.B, bus.C);
      end else begin
        exp_t = sb.pop_front();
        exp_y = exp_t[95:64] + exp_t[63:32] - exp_t[31:0];
        obs_y = bus.A + bus.B - bus.C;
        n_cmp++;
        if ({bus.A, bus.B, bus.C} !== exp_t) begin
          n_err++;
          $display("FAIL triple: got %h/%h/%h, required %h/%h/%h", bus.A, bus.B, bus.C,
                   exp_t[95:64], exp_t[63:32], exp_t[31:0]);
        end
        n_cmp++;
        if (obs_y !== exp_y) begin
          n_err++;
          $display("FAIL y: got %h, required %h", obs_y, exp_y);
        end
        out_cycles.push_back(cyc);
      end
    end
  end

  task automatic send_word(input logic [31:0] w);
    int unsigned waited = 0;
    bit done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = w;
    while (!done) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) begin
        done = 1'b1;
      end else begin
        waited++;
        stalls++;
        if (waited > 20) begin
          n_cmp++;
          n_err++;
          $display("FAIL send_timeout: word %h not accepted in 20 cycles, required acceptance", w);
          done = 1'b1;
        end
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %b, required 0", bus.out_valid); end
    n_cmp++;
    if ({bus.A, bus.B, bus.C} !== 96'd0) begin n_err++; $display("FAIL rst_abc: got %h/%h/%h, required 0", bus.A, bus.B, bus.C); end
    n_cmp++;
    if (triple_count !== 16'd0) begin n_err++; $display("FAIL rst_count: got %0d, required 0", triple_count); end
    rst = 1'b0;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin n_err++; $display("FAIL rst_in_ready: got %b, required 1", bus.in_ready); end
  endtask

  task automatic test_single();
    bus.out_ready = 1'b1;
    sb.push_back({32'd5, 32'd7, 32'd3});
    send_word(32'd5);
    send_word(32'd7);
    send_word(32'd3);
    bus.in_valid = 1'b0;
    n_cmp++;
    if (bus.out_valid !== 1'b1) begin n_err++; $display("FAIL single_valid: got %b, required 1", bus.out_valid); end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin n_err++; $display("FAIL single_pulse: got %b, required 0", bus.out_valid); end
    n_cmp++;
    if (triple_count !== 16'd1) begin n_err++; $display("FAIL single_count: got %0d, required 1", triple_count); end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 1'b0;
    sb.push_back({32'hFFFF_FFFF, 32'd1, 32'd2});
    send_word(32'hFFFF_FFFF);
    send_word(32'd1);
    send_word(32'd2);
    bus.in_valid = 1'b1;
    bus.in_data  = 32'hDEAD_BEEF;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready[%0d]: got %b, required 0", i, bus.in_ready); end
      n_cmp++;
      if ({bus.out_valid, bus.A, bus.B, bus.C} !== {1'b1, 32'hFFFF_FFFF, 32'd1, 32'd2}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got v=%b %h/%h/%h, required v=1 ffffffff/1/2", i, bus.out_valid, bus.A, bus.B, bus.C);
      end
      @(posedge clk); #1;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (triple_count !== 16'd2) begin n_err++; $display("FAIL bp_count: got %0d, required 2", triple_count); end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    stalls = 0;
    out_cycles.delete();
    for (int t = 0; t < 3; t++)
      sb.push_back({32'(100 + 3 * t), 32'(101 + 3 * t), 32'(102 + 3 * t)});
    for (int w = 0; w < 9; w++)
      send_word(32'(100 + w));
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (stalls !== 0) begin n_err++; $display("FAIL b2b_stalls: got %0d, required 0", stalls); end
    n_cmp++;
    if (out_cycles.size() !== 3) begin
      n_err++;
      $display("FAIL b2b_outputs: got %0d, required 3", out_cycles.size());
    end else begin
      n_cmp++;
      if ((out_cycles[1] - out_cycles[0] !== 3) || (out_cycles[2] - out_cycles[1] !== 3)) begin
        n_err++;
        $display("FAIL b2b_spacing: got %0d,%0d, required 3,3",
                 out_cycles[1] - out_cycles[0], out_cycles[2] - out_cycles[1]);
      end
    end
    n_cmp++;
    if (triple_count !== 16'd5) begin n_err++; $display("FAIL b2b_count: got %0d, required 5", triple_count); end
  endtask

  task automatic test_flush();
    bus.out_ready = 1'b1;
    send_word(32'd10);
    send_word(32'd20);
    flush = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'd30;
    @(posedge clk); #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    n_cmp++;
    if ({bus.out_valid, bus.A, bus.B} !== {1'b0, 64'd0}) begin
      n_err++;
      $display("FAIL flush_clear: got v=%b A=%h B=%h, required v=0 A=0 B=0", bus.out_valid, bus.A, bus.B);
    end
    n_cmp++;
    if (triple_count !== 16'd5) begin n_err++; $display("FAIL flush_count: got %0d, required 5", triple_count); end
    sb.push_back({32'd1, 32'd2, 32'd3});
    send_word(32'd1);
    send_word(32'd2);
    send_word(32'd3);
    bus.in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (triple_count !== 16'd6) begin n_err++; $display("FAIL flush_next_count: got %0d, required 6", triple_count); end
    // Flush a pending triple on a cycle where the output handshake would complete.
    bus.out_ready = 1'b0;
    send_word(32'd7);
    send_word(32'd8);
    send_word(32'd9);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    n_cmp++;
    if ({bus.out_valid, triple_count} !== {1'b0, 16'd6}) begin
      n_err++;
      $display("FAIL flush_pending: got v=%b count=%0d, required v=0 count=6", bus.out_valid, triple_count);
    end
  endtask

  task automatic test_wrap();
    bus4.out_ready = 1'b1;
    for (int w = 0; w < 48; w++) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = 32'(w);
      @(posedge clk); #1;
    end
    bus4.in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (cnt4 !== 4'd0) begin n_err++; $display("FAIL wrap_16: got %0d, required 0", cnt4); end
    for (int w = 0; w < 3; w++) begin
      bus4.in_valid = 1'b1;
      bus4.in_data  = 32'(w);
      @(posedge clk); #1;
    end
    bus4.in_valid = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (cnt4 !== 4'd1) begin n_err++; $display("FAIL wrap_17: got %0d, required 1", cnt4); end
  endtask

  initial begin
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.out_ready  = 1'b0;
    bus4.in_valid  = 1'b0;
    bus4.in_data   = '0;
    bus4.out_ready = 1'b0;
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_flush();
    test_wrap();
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (sb.size() !== 0) begin n_err++; $display("FAIL sb_drain: got %0d pending, required 0", sb.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
